traffic_light_top: RTL and testbench

TRAFFIC_LIGHT_TOP -- requirements
Module: traffic_light_top

---
 rtl/traffic_light_top.sv | 130 +++++++++++++
 tb/tb_traffic_light_top.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/traffic_light_top.sv
// Five-phase traffic light controller: a Moore FSM sequenced by a single phase
// counter, with the flashing-green lamp derived from that counter.
`timescale 1ns/1ps
module traffic_light_top #(
   parameter int unsigned RED_CYC        = 2000,
   parameter int unsigned RED_YEL_CYC    = 500,
   parameter int unsigned GREEN_CYC      = 2000,
   parameter int unsigned BLINK_HALF_CYC = 250,
   parameter int unsigned BLINK_NUM      = 3,
   parameter int unsigned YEL_CYC        = 500
) (
   input  logic clk,
   input  logic btn,
   output logic led0,
   output logic led1,
   output logic led2
);

   function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned BLINK_CYC = 2 * BLINK_HALF_CYC * BLINK_NUM;
   localparam int unsigned MAX_LEN   = maxOf(maxOf(maxOf(RED_CYC, RED_YEL_CYC), maxOf(GREEN_CYC, BLINK_CYC)), YEL_CYC);
   // Counter only ever holds 0..MAX_LEN-1; keep at least one bit when every phase is a single cycle.
   localparam int unsigned CNT_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [CNT_W-1:0] RED_LAST     = CNT_W'(RED_CYC - 1);
   localparam logic [CNT_W-1:0] RED_YEL_LAST = CNT_W'(RED_YEL_CYC - 1);
   localparam logic [CNT_W-1:0] GREEN_LAST   = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_CYC - 1);
   localparam logic [CNT_W-1:0] YEL_LAST     = CNT_W'(YEL_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LEN     = CNT_W'(BLINK_HALF_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   typedef enum logic [2:0] {
      RED         = 3'd0,
      RED_YEL     = 3'd1,
      GREEN       = 3'd2,
      GREEN_BLINK = 3'd3,
      YELLOW      = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blinkOn;

   always_ff @(posedge clk or negedge btn) begin
      if (!btn) begin
         state_q <= RED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Each phase advances when its counter reaches length-1; stray encodings fall back to RED.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_ONE;
      unique case (state_q)
         RED: begin
            if (cnt_q == RED_LAST) begin
               state_d = RED_YEL;
               cnt_d   = '0;
            end
         end
         RED_YEL: begin
            if (cnt_q == RED_YEL_LAST) begin
               state_d = GREEN;
               cnt_d   = '0;
            end
         end
         GREEN: begin
            if (cnt_q == GREEN_LAST) begin
               state_d = GREEN_BLINK;
               cnt_d   = '0;
            end
         end
         GREEN_BLINK: begin
            if (cnt_q == BLINK_LAST) begin
               state_d = YELLOW;
               cnt_d   = '0;
            end
         end
         YELLOW: begin
            if (cnt_q == YEL_LAST) begin
               state_d = RED;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RED;
            cnt_d   = '0;
         end
      endcase
   end

   // Odd half-periods light the lamp, so the flash opens dark and closes lit.
   assign blinkOn = ((cnt_q / HALF_LEN) & CNT_ONE) != '0;

   always_comb begin
      led0 = 1'b0;
      led1 = 1'b0;
      led2 = 1'b0;
      unique case (state_q)
         RED: begin
            led0 = 1'b1;
         end
         RED_YEL: begin
            led0 = 1'b1;
            led1 = 1'b1;
         end
         GREEN: begin
            led2 = 1'b1;
         end
         GREEN_BLINK: begin
            led2 = blinkOn;
         end
         YELLOW: begin
            led1 = 1'b1;
         end
         default: begin
            led0 = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_traffic_light_top.sv
// Scoreboard bench for traffic_light_top: default and all-ones parameterisations
// run side by side against a phase-table model, with random mid-phase resets.
`timescale 1ns/1ps
module tb_traffic_light_top;

   localparam int DEF_PERIOD = 2000 + 500 + 2000 + 2 * 250 * 3 + 500;
   localparam int BLINK_START = 2000 + 500 + 2000;
   localparam int BLINK_LEN = 2 * 250 * 3;

   typedef struct {
      logic [2:0] expDef;
      logic [2:0] expMin;
      string      tag;
   } exp_t;

   logic clk = 1'b0;
   logic btn;
   logic defLed0, defLed1, defLed2;
   logic minLed0, minLed1, minLed2;

   int   edgeCnt = 0;
   int   passCount = 0;
   int   checkCount = 0;
   exp_t sbQ[$];
   event sampleEv;

   always #5 clk = ~clk;

   traffic_light_top dutDef (
      .clk  (clk),
      .btn  (btn),
      .led0 (defLed0),
      .led1 (defLed1),
      .led2 (defLed2)
   );

   traffic_light_top #(
      .RED_CYC        (1),
      .RED_YEL_CYC    (1),
      .GREEN_CYC      (1),
      .BLINK_HALF_CYC (1),
      .BLINK_NUM      (1),
      .YEL_CYC        (1)
   ) dutMin (
      .clk  (clk),
      .btn  (btn),
      .led0 (minLed0),
      .led1 (minLed1),
      .led2 (minLed2)
   );

   // Lamps {red,yellow,green} as a function of clock edges seen since reset release.
   function automatic logic [2:0] refLeds(input int e, input int r, input int ry, input int g,
                                          input int h, input int n, input int y);
      int p;
      p = e % (r + ry + g + 2 * h * n + y);
      if (p < r) return 3'b100;
      p = p - r;
      if (p < ry) return 3'b110;
      p = p - ry;
      if (p < g) return 3'b001;
      p = p - g;
      if (p < 2 * h * n) return (((p / h) % 2) == 1) ? 3'b001 : 3'b000;
      return 3'b010;
   endfunction

   always @(posedge clk) begin
      if (btn) edgeCnt = edgeCnt + 1;
   end

   task automatic pushExpect(input string tag);
      exp_t item;
      item.expDef = refLeds(edgeCnt, 2000, 500, 2000, 250, 3, 500);
      item.expMin = refLeds(edgeCnt, 1, 1, 1, 1, 1, 1);
      item.tag    = tag;
      sbQ.push_back(item);
   endtask

   task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s at t=%0t edge=%0d: got leds=%b, expected %b",
                    name, $time, edgeCnt, actual, expected);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         pushExpect("cycle");
         ->sampleEv;
      end
   end

   initial begin
      exp_t item;
      forever begin
         @(sampleEv);
         if (sbQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard_empty at t=%0t: got no entry, expected one", $time);
         end else begin
            item = sbQ.pop_front();
            checkOutput({item.tag, "_default"}, {defLed0, defLed1, defLed2}, item.expDef);
            checkOutput({item.tag, "_minimal"}, {minLed0, minLed1, minLed2}, item.expMin);
         end
      end
   end

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
   endtask

   // Called just after a rising edge: drops btn off-edge and checks the lamps before any clock.
   task automatic applyReset(input int holdCycles);
      #1;
      btn = 1'b0;
      edgeCnt = 0;
      #1;
      pushExpect("async_reset");
      ->sampleEv;
      repeat (holdCycles) @(posedge clk);
      #2;
      btn = 1'b1;
   endtask

   initial begin
      int target;
      int guard;
      btn = 1'b0;
      $display("[TB] reset held, then free run");
      applyStimulus(5);
      #2;
      btn = 1'b1;
      applyStimulus(15000);

      target = BLINK_START + $urandom_range(0, BLINK_LEN - 1);
      $display("[TB] reset during flashing green at phase position %0d", target);
      guard = 0;
      while ((edgeCnt % DEF_PERIOD) != target && guard < 2 * DEF_PERIOD) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checkCount++;
      if (guard < 2 * DEF_PERIOD) passCount++;
      else $display("[TB] FAIL blink_wait_timeout: got no blink position after %0d cycles, expected %0d", guard, target);
      #1;
      @(posedge clk);
      applyReset($urandom_range(1, 5));
      applyStimulus(7000);

      for (int k = 0; k < 3; k++) begin
         applyStimulus($urandom_range(1, DEF_PERIOD));
         applyReset($urandom_range(1, 8));
         applyStimulus(2600);
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
